// File: rtl/multi_cycle_unit_sequencer.sv
// Multi-cycle execute unit sequencer: issues one op at a time to the Fp32,
// Fp64 or MulDiv unit, holds the unit enable until done, captures the
// result and holds it until the downstream stage accepts it. Handles
// pipeline flush, a watchdog abort and the execute-stage stall request.
module multi_cycle_unit_sequencer #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned FLEN           = 64,
    parameter int unsigned NUM_UNITS      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issueValid,
    input  logic [1:0]                issueUnit,
    input  logic [4:0]                issueTag,
    output logic                      issueReady,
    input  logic                      flush,
    output logic [NUM_UNITS-1:0]      unitEnable,
    output logic [NUM_UNITS-1:0]      unitFlush,
    input  logic [NUM_UNITS-1:0]      unitDone,
    input  logic [NUM_UNITS*XLEN-1:0] unitIntResult,
    input  logic [NUM_UNITS*FLEN-1:0] unitFpResult,
    input  logic [NUM_UNITS*5-1:0]    unitFflags,
    input  logic [NUM_UNITS-1:0]      unitFflagsWrite,
    output logic                      resultValid,
    input  logic                      resultAccept,
    output logic [1:0]                resultUnit,
    output logic [4:0]                resultTag,
    output logic [XLEN-1:0]           resultInt,
    output logic [FLEN-1:0]           resultFp,
    output logic [4:0]                resultFflags,
    output logic                      resultFflagsWrite,
    output logic                      stallReq,
    output logic                      timeout,
    output logic [7:0]                busyCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        HOLD  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0] cur_unit;
    logic [4:0] cur_tag;

    logic       issue_ok;
    logic       load_issue;
    logic       capture;
    logic       done_cur;
    logic       timeout_hit;
    logic [1:0] next_unit;

    logic [XLEN-1:0] sel_int;
    logic [FLEN-1:0] sel_fp;
    logic [4:0]      sel_fflags;
    logic            sel_fflags_write;

    // Decode a unit index into a one-hot vector; out-of-range indices give zero.
    function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [1:0] idx);
        logic [NUM_UNITS-1:0] vec;
        vec = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (32'(idx) == i) begin
                vec[i] = 1'b1;
            end
        end
        return vec;
    endfunction

    // Select the current unit's result slices for capture.
    always_comb begin
        sel_int          = '0;
        sel_fp           = '0;
        sel_fflags       = '0;
        sel_fflags_write = 1'b0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (32'(cur_unit) == i) begin
                sel_int          = unitIntResult[i*XLEN +: XLEN];
                sel_fp           = unitFpResult[i*FLEN +: FLEN];
                sel_fflags       = unitFflags[i*5 +: 5];
                sel_fflags_write = unitFflagsWrite[i];
            end
        end
    end

    // Next-state logic with flush > timeout > done priority in BUSY.
    always_comb begin
        state_next  = state;
        load_issue  = 1'b0;
        capture     = 1'b0;
        issue_ok    = issueValid && (32'(issueUnit) < NUM_UNITS) && !flush;
        done_cur    = |(unitDone & unit_onehot(cur_unit));
        timeout_hit = (state == BUSY) && !flush && !done_cur &&
                      (32'(busyCount) == TIMEOUT_CYCLES - 1);

        case (state)
            IDLE: begin
                if (issue_ok) begin
                    load_issue = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_next = ABORT;
                end else if (timeout_hit) begin
                    state_next = ABORT;
                end else if (done_cur) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (resultAccept) begin
                    if (issue_ok) begin
                        load_issue = 1'b1;
                        state_next = BUSY;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            ABORT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        next_unit = load_issue ? issueUnit : cur_unit;
    end

    // State, op context, busy counter, unit strobes and result capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            cur_unit          <= '0;
            cur_tag           <= '0;
            busyCount         <= '0;
            unitEnable        <= '0;
            unitFlush         <= '0;
            resultValid       <= 1'b0;
            resultUnit        <= '0;
            resultTag         <= '0;
            resultInt         <= '0;
            resultFp          <= '0;
            resultFflags      <= '0;
            resultFflagsWrite <= 1'b0;
        end else begin
            state <= state_next;

            if (load_issue) begin
                cur_unit <= issueUnit;
                cur_tag  <= issueTag;
            end

            if (load_issue) begin
                busyCount <= '0;
            end else if ((state == BUSY) && (busyCount != 8'hFF)) begin
                busyCount <= busyCount + 8'd1;
            end

            // Strobes are registered from the next state so they line up
            // with the state they belong to.
            unitEnable  <= (state_next == BUSY)  ? unit_onehot(next_unit) : '0;
            unitFlush   <= (state_next == ABORT) ? unit_onehot(cur_unit)  : '0;
            resultValid <= (state_next == HOLD);

            if (capture) begin
                resultUnit        <= cur_unit;
                resultTag         <= cur_tag;
                resultInt         <= sel_int;
                resultFp          <= sel_fp;
                resultFflags      <= sel_fflags;
                resultFflagsWrite <= sel_fflags_write;
            end
        end
    end

    assign issueReady = rst && ((state == IDLE) ||
                                ((state == HOLD) && resultAccept && !flush));
    assign stallReq   = (state == BUSY) || (state == ABORT) ||
                        ((state == HOLD) && !resultAccept);
    assign timeout    = timeout_hit;

    a_enable_onehot : assert property (@(posedge clk) disable iff (!rst)
        $onehot0(unitEnable));
    a_flush_onehot : assert property (@(posedge clk) disable iff (!rst)
        $onehot0(unitFlush));
    a_enable_only_busy : assert property (@(posedge clk) disable iff (!rst)
        (state != BUSY) |-> (unitEnable == '0));

endmodule

// File: doc/multi_cycle_unit_sequencer.md
Name: multi_cycle_unit_sequencer

Overview:
Sequences the multi-cycle execute units (Fp32, Fp64, MulDiv) for the execute stage. It accepts one issued op at a time and drives a level enable to the selected unit until that unit signals done. It then captures and holds the unit's result until the downstream stage accepts it. It also handles flush and a watchdog timeout, and produces the execute-stage stall request.

Parameters:
XLEN, 32, integer result width
FLEN, 64, FP result width
NUM_UNITS, 3, number of sequenced units; unit index 0=Fp32, 1=Fp64, 2=MulDiv
TIMEOUT_CYCLES, 64, maximum number of BUSY cycles before abort (range 2..255)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low (rst==0 resets on the rising edge of clk)
issueValid  in  1  op offered for issue
issueUnit  in  2  target unit index; values >= NUM_UNITS mean no unit
issueTag  in  5  destination register address carried with the op
issueReady  out  1  sequencer can accept an issue this cycle
flush  in  1  pipeline flush
unitEnable  out  NUM_UNITS  one-hot level enable to the active unit
unitFlush  out  NUM_UNITS  one-hot, one-cycle abort pulse to a unit
unitDone  in  NUM_UNITS  per-unit done
unitIntResult  in  NUM_UNITS*XLEN  packed integer results; unit i occupies bits [i*XLEN +: XLEN]
unitFpResult  in  NUM_UNITS*FLEN  packed FP results
unitFflags  in  NUM_UNITS*5  packed fflags values
unitFflagsWrite  in  NUM_UNITS  per-unit fflags write strobe
resultValid  out  1  held result available
resultAccept  in  1  downstream consumes the held result
resultUnit  out  2  unit that produced the result
resultTag  out  5  tag of the op
resultInt  out  XLEN  captured integer result
resultFp  out  FLEN  captured FP result
resultFflags  out  5  captured fflags value
resultFflagsWrite  out  1  captured fflags write strobe
stallReq  out  1  execute-stage stall request
timeout  out  1  one-cycle pulse when the watchdog aborts an op
busyCount  out  8  number of BUSY cycles elapsed for the current op

Behaviour:
- Reset (rst==0): state returns to IDLE. All registered outputs and result registers clear to 0: unitEnable, unitFlush, resultValid, result fields, timeout, busyCount. No unitFlush pulse is issued on reset, even if reset arrives mid-operation.
- State machine has four states: IDLE, BUSY, HOLD, ABORT.
- IDLE:
  - An issue is accepted when issueValid && issueUnit<NUM_UNITS && !flush. On accept: latch unit and tag, clear busyCount, go to BUSY.
  - issueValid with an out-of-range issueUnit is ignored; the state does not change.
- BUSY:
  - unitEnable[cur]=1. busyCount increments once per cycle and saturates at 255.
  - Transition priority: flush > timeout > done.
  - flush: go to ABORT.
  - Timeout: when busyCount==TIMEOUT_CYCLES-1 and unitDone[cur]==0, pulse timeout for one cycle and go to ABORT.
  - unitDone[cur]: capture result[cur], int, fp, fflags and fflagsWrite, then go to HOLD.
  - unitDone on any non-current unit is ignored.
- ABORT lasts exactly 1 cycle:
  - unitEnable=0, unitFlush[cur]=1, issueReady=0, then go to IDLE.
  - No result is produced. An unitDone arriving in this cycle is discarded.
- HOLD:
  - resultValid=1 and all result fields are stable.
  - flush: drop the result and go to IDLE. flush has priority over resultAccept.
  - resultAccept without flush: if a valid issue is present in the same cycle, go directly to BUSY (back-to-back); otherwise go to IDLE.
- Combinational outputs:
  - issueReady = (state==IDLE) || (state==HOLD && resultAccept && !flush).
  - stallReq = (state==BUSY) || (state==ABORT) || (state==HOLD && !resultAccept).
- Latency:
  - Issue accepted at edge T; unitEnable is high from T+1.
  - If the unit raises done at cycle T+k, resultValid is high from T+k+1.
  - Minimum issue-to-result latency is 2 cycles.
- unitEnable is never asserted in IDLE, HOLD or ABORT. At most one bit of unitEnable or unitFlush is ever set.

Test Plan:
- Reset: hold rst=0 for 2 cycles with issueValid=1 -> unitEnable=0, resultValid=0, issueReady=0; after release, issueReady=1.
- Normal MulDiv op: issue unit 2, tag 5'd7; unitDone[2] raised 4 cycles after enable with unitIntResult slice=32'h0000_002A -> resultValid=1, resultInt=0x2A, resultTag=7, resultUnit=2, stallReq deasserts in the accept cycle.
- Back-to-back: in HOLD, assert resultAccept and issue unit 0 in the same cycle -> next cycle unitEnable=3'b001 and busyCount=0.
- Flush in BUSY coincident with unitDone[1] -> next cycle unitFlush=3'b010; no resultValid; IDLE after 1 cycle.
- Watchdog: TIMEOUT_CYCLES=8, unit never done -> timeout pulse at busyCount=7, then unitFlush pulse, then IDLE.
- Ignored inputs: issueUnit=3 -> no state change; unitDone[0] while unit 1 is busy -> ignored.
